// File: rtl/control_cmd_fillarea_pkg.sv
// Shared types and panel parameters for the fill-area command front end.
// Coordinates are clipped in uint_t so nothing wraps before truncation.
package control_cmd_fillarea_pkg;

    localparam int BYTES_PER_PIXEL    = 2;
    localparam int PIXEL_WIDTH        = 64;
    localparam int PIXEL_HEIGHT       = 32;
    localparam int FILLAREA_ARG_BYTES = 4 + BYTES_PER_PIXEL;

    localparam int COL_W = $clog2(PIXEL_WIDTH);
    localparam int ROW_W = $clog2(PIXEL_HEIGHT);
    localparam int CLR_W = 8 * BYTES_PER_PIXEL;
    localparam int CNT_W = $clog2(FILLAREA_ARG_BYTES + 1);

    typedef logic [COL_W-1:0] col_addr_t;
    typedef logic [ROW_W-1:0] row_addr_t;
    typedef logic [CLR_W-1:0] color_t;
    typedef logic [31:0]      uint_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARGS,
        S_CLIP,
        S_RUN,
        S_SUBACK,
        S_DONE,
        S_WAIT
    } fillarea_cmd_state_t;

    function automatic uint_t umin(input uint_t a, input uint_t b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/control_fillarea_clip.sv
// Clips a fill rectangle to the panel and flags rectangles that are empty
// or start off-panel; full-size extents truncate to 0 in the address types.
module control_fillarea_clip
    import control_cmd_fillarea_pkg::*;
(
    input  logic [7:0] i_x1,
    input  logic [7:0] i_y1,
    input  logic [7:0] i_width,
    input  logic [7:0] i_height,
    output col_addr_t  o_width,
    output row_addr_t  o_height,
    output logic       o_reject
);

    uint_t w_x1;
    uint_t w_y1;
    uint_t w_w;
    uint_t w_h;

    always_comb begin
        w_x1 = uint_t'(i_x1);
        w_y1 = uint_t'(i_y1);
        w_w  = uint_t'(i_width);
        w_h  = uint_t'(i_height);
        o_reject = (w_x1 >= uint_t'(PIXEL_WIDTH))
                || (w_y1 >= uint_t'(PIXEL_HEIGHT))
                || (w_w == '0) || (w_h == '0);
        o_width  = '0;
        o_height = '0;
        if (!o_reject) begin
            o_width  = col_addr_t'(umin(w_w,
                           uint_t'(PIXEL_WIDTH) - w_x1));
            o_height = row_addr_t'(umin(w_h,
                           uint_t'(PIXEL_HEIGHT) - w_y1));
        end
    end

endmodule

// File: rtl/control_cmd_fillarea.sv
// Fill-area command front end: gathers arguments, clips, runs the
// downstream fill engine and handshakes completion back to the decoder.
module control_cmd_fillarea
    import control_cmd_fillarea_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_enable,
    input  logic [7:0] i_data_rx,
    input  logic       i_data_rx_valid,
    input  logic       i_ack,
    output logic       o_done,
    output logic       o_sub_enable,
    output col_addr_t  o_sub_x1,
    output row_addr_t  o_sub_y1,
    output col_addr_t  o_sub_width,
    output row_addr_t  o_sub_height,
    output color_t     o_sub_color,
    input  logic       i_sub_done,
    output logic       o_sub_ack,
    output logic       o_byte_dropped
);

    localparam logic [CNT_W-1:0] LAST_IDX =
        CNT_W'(FILLAREA_ARG_BYTES - 1);

    fillarea_cmd_state_t r_state;
    fillarea_cmd_state_t w_next;

    logic [CNT_W-1:0] r_count;
    logic [7:0]       r_args [FILLAREA_ARG_BYTES];
    col_addr_t        r_x1;
    row_addr_t        r_y1;
    col_addr_t        r_width;
    row_addr_t        r_height;
    color_t           r_color;
    logic             r_byte_dropped;

    col_addr_t w_clip_w;
    row_addr_t w_clip_h;
    logic      w_reject;
    color_t    w_color;
    logic      w_store;
    logic      w_drop;

    control_fillarea_clip u_clip (
        .i_x1     (r_args[0]),
        .i_y1     (r_args[1]),
        .i_width  (r_args[2]),
        .i_height (r_args[3]),
        .o_width  (w_clip_w),
        .o_height (w_clip_h),
        .o_reject (w_reject)
    );

    // Colour arrives MSB first after the four coordinate bytes.
    always_comb begin
        w_color = '0;
        for (int i = 0; i < BYTES_PER_PIXEL; i++) begin
            w_color[8*(BYTES_PER_PIXEL-1-i) +: 8] = r_args[4+i];
        end
    end

    always_comb begin
        w_next  = r_state;
        w_store = 1'b0;
        unique case (r_state)
            S_IDLE:   if (i_enable) w_next = S_ARGS;
            S_ARGS: begin
                if (!i_enable) begin
                    w_next = S_IDLE;
                end else if (i_data_rx_valid) begin
                    w_store = 1'b1;
                    if (r_count == LAST_IDX) w_next = S_CLIP;
                end
            end
            S_CLIP:   w_next = w_reject ? S_DONE : S_RUN;
            S_RUN:    if (i_sub_done) w_next = S_SUBACK;
            S_SUBACK: w_next = S_DONE;
            S_DONE:   if (i_ack) w_next = S_WAIT;
            S_WAIT:   if (!i_enable) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
        w_drop = i_enable && i_data_rx_valid
              && (r_state != S_IDLE) && (r_state != S_ARGS);
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state        <= S_IDLE;
            r_count        <= '0;
            r_x1           <= '0;
            r_y1           <= '0;
            r_width        <= '0;
            r_height       <= '0;
            r_color        <= '0;
            r_byte_dropped <= 1'b0;
            for (int i = 0; i < FILLAREA_ARG_BYTES; i++) begin
                r_args[i] <= '0;
            end
        end else begin
            r_state        <= w_next;
            r_byte_dropped <= w_drop;
            if (r_state == S_IDLE) begin
                r_count <= '0;
            end else if (w_store) begin
                r_count <= r_count + 1'b1;
            end
            for (int i = 0; i < FILLAREA_ARG_BYTES; i++) begin
                if (w_store && r_count == CNT_W'(i)) begin
                    r_args[i] <= i_data_rx;
                end
            end
            if (r_state == S_CLIP && !w_reject) begin
                r_x1     <= col_addr_t'(r_args[0]);
                r_y1     <= row_addr_t'(r_args[1]);
                r_width  <= w_clip_w;
                r_height <= w_clip_h;
                r_color  <= w_color;
            end
        end
    end

    assign o_done         = (r_state == S_DONE);
    assign o_sub_enable   = (r_state == S_RUN) || (r_state == S_SUBACK);
    assign o_sub_ack      = (r_state == S_SUBACK);
    assign o_sub_x1       = r_x1;
    assign o_sub_y1       = r_y1;
    assign o_sub_width    = r_width;
    assign o_sub_height   = r_height;
    assign o_sub_color    = r_color;
    assign o_byte_dropped = r_byte_dropped;

endmodule

// File: tb/tb_control_cmd_fillarea.sv
// Bench for control_cmd_fillarea with a behavioural fill engine as load.
// Expected results come from a vector table pushed through a scoreboard.
module tb_control_cmd_fillarea;
    import control_cmd_fillarea_pkg::*;

    logic       clk = 1'b0;
    logic       i_reset = 1'b0;
    logic       i_enable = 1'b0;
    logic [7:0] i_data_rx = '0;
    logic       i_data_rx_valid = 1'b0;
    logic       i_ack = 1'b0;
    logic       o_done;
    logic       o_sub_enable;
    col_addr_t  o_sub_x1;
    row_addr_t  o_sub_y1;
    col_addr_t  o_sub_width;
    row_addr_t  o_sub_height;
    color_t     o_sub_color;
    logic       i_sub_done;
    logic       o_sub_ack;
    logic       o_byte_dropped;

    always #5 clk = ~clk;

    control_cmd_fillarea dut (
        .i_clk           (clk),
        .i_reset         (i_reset),
        .i_enable        (i_enable),
        .i_data_rx       (i_data_rx),
        .i_data_rx_valid (i_data_rx_valid),
        .i_ack           (i_ack),
        .o_done          (o_done),
        .o_sub_enable    (o_sub_enable),
        .o_sub_x1        (o_sub_x1),
        .o_sub_y1        (o_sub_y1),
        .o_sub_width     (o_sub_width),
        .o_sub_height    (o_sub_height),
        .o_sub_color     (o_sub_color),
        .i_sub_done      (i_sub_done),
        .o_sub_ack       (o_sub_ack),
        .o_byte_dropped  (o_byte_dropped)
    );

    // Behavioural fill engine: two byte writes per pixel, row-major.
    typedef enum {M_IDLE, M_RUN, M_DONE, M_WAIT} mst_t;
    mst_t      m_st = M_IDLE;
    col_addr_t m_x1;
    row_addr_t m_y1;
    col_addr_t m_wr;
    row_addr_t m_hr;
    color_t    m_col;
    int        m_W, m_H, m_px, m_b;
    int        m_writes = 0;
    int        m_en_cycles = 0;
    int        m_xmin, m_xmax, m_ymin, m_ymax;
    bit        m_unstable;
    logic      sub_done_r = 1'b0;
    int        wx, wy;

    assign i_sub_done = sub_done_r;

    always @(posedge clk) begin
        if (o_sub_enable) m_en_cycles <= m_en_cycles + 1;
        if (!i_reset) begin
            m_st       <= M_IDLE;
            sub_done_r <= 1'b0;
        end else begin
            case (m_st)
                M_IDLE: if (o_sub_enable) begin
                    m_x1  <= o_sub_x1;
                    m_y1  <= o_sub_y1;
                    m_wr  <= o_sub_width;
                    m_hr  <= o_sub_height;
                    m_col <= o_sub_color;
                    m_W   <= (o_sub_width == '0) ? PIXEL_WIDTH
                             : int'(o_sub_width);
                    m_H   <= (o_sub_height == '0) ? PIXEL_HEIGHT
                             : int'(o_sub_height);
                    m_px  <= 0;
                    m_b   <= 0;
                    m_xmin <= 9999;
                    m_xmax <= -1;
                    m_ymin <= 9999;
                    m_ymax <= -1;
                    m_unstable <= 1'b0;
                    m_st  <= M_RUN;
                end
                M_RUN: begin
                    wx = int'(m_x1) + (m_px % m_W);
                    wy = int'(m_y1) + (m_px / m_W);
                    m_writes <= m_writes + 1;
                    if (wx < m_xmin) m_xmin <= wx;
                    if (wx > m_xmax) m_xmax <= wx;
                    if (wy < m_ymin) m_ymin <= wy;
                    if (wy > m_ymax) m_ymax <= wy;
                    if (o_sub_x1 !== m_x1 || o_sub_y1 !== m_y1
                        || o_sub_width !== m_wr
                        || o_sub_height !== m_hr
                        || o_sub_color !== m_col || !o_sub_enable)
                        m_unstable <= 1'b1;
                    if (m_b == 1) begin
                        m_b <= 0;
                        if (m_px == m_W * m_H - 1) begin
                            m_st       <= M_DONE;
                            sub_done_r <= 1'b1;
                        end else begin
                            m_px <= m_px + 1;
                        end
                    end else begin
                        m_b <= 1;
                    end
                end
                M_DONE: if (o_sub_ack) begin
                    sub_done_r <= 1'b0;
                    m_st       <= M_WAIT;
                end
                M_WAIT: if (!o_sub_enable) m_st <= M_IDLE;
                default: m_st <= M_IDLE;
            endcase
        end
    end

    typedef struct {
        logic [47:0] bytes;
        bit          rej;
        int          x1, y1, w, h;
        logic [15:0] col;
        int          writes, xmin, xmax, ymin, ymax;
    } vec_t;

    vec_t vecs [8];
    vec_t sb_q [$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h",
                     name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        i_data_rx       = b;
        i_data_rx_valid = 1'b1;
        @(negedge clk);
        i_data_rx_valid = 1'b0;
    endtask

    task automatic run_cmd(input vec_t v, input int stray);
        int   w0, e0, t;
        vec_t e;
        sb_q.push_back(v);
        w0 = m_writes;
        e0 = m_en_cycles;
        i_enable = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 6; i++) send_byte(v.bytes[47-8*i -: 8]);
        chk("lat_minus1_done", 32'(o_done), 32'd0);
        @(negedge clk);
        if (v.rej) chk("rej_done_lat", 32'(o_done), 32'd1);
        else       chk("run_en_lat", 32'(o_sub_enable), 32'd1);
        if (stray > 0) begin
            repeat (stray) @(negedge clk);
            send_byte(8'hEE);
            chk("stray_pulse", 32'(o_byte_dropped), 32'd1);
            @(negedge clk);
            chk("stray_once", 32'(o_byte_dropped), 32'd0);
        end
        t = 0;
        while (!o_done && t < 10000) begin
            @(negedge clk);
            t++;
        end
        chk("done_wait", 32'(t < 10000), 32'd1);
        e = sb_q.pop_front();
        chk("writes", 32'(m_writes - w0), 32'(e.writes));
        if (e.rej) begin
            chk("rej_no_en", 32'(m_en_cycles - e0), 32'd0);
        end else begin
            chk("sub_x1", 32'(o_sub_x1), 32'(col_addr_t'(e.x1)));
            chk("sub_y1", 32'(o_sub_y1), 32'(row_addr_t'(e.y1)));
            chk("sub_w", 32'(o_sub_width), 32'(col_addr_t'(e.w)));
            chk("sub_h", 32'(o_sub_height), 32'(row_addr_t'(e.h)));
            chk("sub_color", 32'(o_sub_color), 32'(e.col));
            chk("box_xmin", m_xmin, e.xmin);
            chk("box_xmax", m_xmax, e.xmax);
            chk("box_ymin", m_ymin, e.ymin);
            chk("box_ymax", m_ymax, e.ymax);
            chk("stable", 32'(m_unstable), 32'd0);
        end
        repeat (3) @(negedge clk);
        chk("done_held", 32'(o_done), 32'd1);
        i_ack = 1'b1;
        @(negedge clk);
        i_ack = 1'b0;
        chk("done_clr", 32'(o_done), 32'd0);
        @(negedge clk);
        chk("wait_no_rerun", 32'(o_sub_enable | o_done), 32'd0);
        i_enable = 1'b0;
        repeat (2) @(negedge clk);
        chk("back_idle", 32'(dut.r_state), 32'(S_IDLE));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t one;
        vecs[0] = '{48'h0000_4020_A55A, 0, 0, 0, 64, 32, 16'hA55A,
                    4096, 0, 63, 0, 31};
        vecs[1] = '{48'h3C1E_1010_FF00, 0, 60, 30, 4, 2, 16'hFF00,
                    16, 60, 63, 30, 31};
        vecs[2] = '{48'h4000_0404_1234, 1, 0, 0, 0, 0, 16'h0,
                    0, 0, 0, 0, 0};
        vecs[3] = '{48'h0A05_0304_1234, 0, 10, 5, 3, 4, 16'h1234,
                    24, 10, 12, 5, 8};
        vecs[4] = '{48'h3E00_FF01_C33C, 0, 62, 0, 2, 1, 16'hC33C,
                    4, 62, 63, 0, 0};
        vecs[5] = '{48'h0000_0005_7777, 1, 0, 0, 0, 0, 16'h0,
                    0, 0, 0, 0, 0};
        vecs[6] = '{48'h0020_0101_8888, 1, 0, 0, 0, 0, 16'h0,
                    0, 0, 0, 0, 0};
        vecs[7] = '{48'h1F1F_2121_0F0F, 0, 31, 31, 33, 1, 16'h0F0F,
                    66, 31, 63, 31, 31};
        one     = '{48'h0000_0101_AABB, 0, 0, 0, 1, 1, 16'hAABB,
                    2, 0, 0, 0, 0};

        repeat (3) @(negedge clk);
        chk("rst_done", 32'(o_done), 32'd0);
        chk("rst_sub_en", 32'(o_sub_enable), 32'd0);
        chk("rst_sub_ack", 32'(o_sub_ack), 32'd0);
        chk("rst_dropped", 32'(o_byte_dropped), 32'd0);
        chk("rst_sub_vals", 32'({o_sub_x1, o_sub_y1, o_sub_width,
                                 o_sub_height} | o_sub_color), 32'd0);
        i_reset = 1'b1;
        @(negedge clk);

        send_byte(8'h55);
        chk("idle_no_drop", 32'(o_byte_dropped), 32'd0);

        for (int i = 0; i < 8; i++) run_cmd(vecs[i], 0);

        run_cmd(vecs[1], 3);

        i_enable = 1'b1;
        @(negedge clk);
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        i_enable        = 1'b0;
        i_data_rx       = 8'h04;
        i_data_rx_valid = 1'b1;
        @(negedge clk);
        i_data_rx_valid = 1'b0;
        chk("abort_state", 32'(dut.r_state), 32'(S_IDLE));
        chk("abort_no_drop", 32'(o_byte_dropped), 32'd0);
        repeat (3) @(negedge clk);
        chk("abort_done", 32'(o_done), 32'd0);
        run_cmd(one, 0);

        i_enable = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 6; i++)
            send_byte(vecs[0].bytes[47-8*i -: 8]);
        repeat (50) @(negedge clk);
        chk("pre_rst_run", 32'(o_sub_enable), 32'd1);
        i_reset = 1'b0;
        @(negedge clk);
        chk("mid_rst_state", 32'(dut.r_state), 32'(S_IDLE));
        chk("mid_rst_outs", 32'({o_done, o_sub_enable, o_sub_ack}),
            32'd0);
        i_enable = 1'b0;
        i_reset  = 1'b1;
        repeat (2) @(negedge clk);
        run_cmd(vecs[3], 0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule
